axi_ram_slave: RTL and testbench

AXI_RAM_SLAVE -- requirements
Module: axi_ram_slave

---
 rtl/axi_ram_slave_pkg.sv | 27 ++
 rtl/axi_ram_slave_burst_addr.sv | 42 ++++
 rtl/axi_ram_slave.sv | 285 ++++++++++++++++++++++++++++
 tb/tb_axi_ram_slave.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_ram_slave_pkg.sv
// Shared constants and state encodings for the AXI RAM slave.
package axi_ram_slave_pkg;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        W_IDLE = 2'b00,
        W_DATA = 2'b01,
        W_RESP = 2'b10
    } w_state_e;

    typedef enum logic {
        R_IDLE = 1'b0,
        R_DATA = 1'b1
    } r_state_e;

    // Only these burst lengths form a legal power-of-two wrap block.
    function automatic logic wrap_len_ok(input logic [7:0] len);
        return (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
    endfunction

endpackage

// File: rtl/axi_ram_slave_burst_addr.sv
// Next-beat address computation for FIXED / INCR / WRAP bursts.
module axi_burst_addr #(
    parameter int ADDR_WIDTH = 32,
    parameter int STRB_WIDTH = 4
) (
    input  logic [ADDR_WIDTH-1:0] addr_i,
    input  logic [7:0]            len_i,
    input  logic [1:0]            burst_i,
    output logic [ADDR_WIDTH-1:0] next_addr_o
);
    import axi_ram_slave_pkg::*;

    localparam int STRB_SHIFT = $clog2(STRB_WIDTH);

    logic [ADDR_WIDTH-1:0] incr_s;
    logic [ADDR_WIDTH-1:0] wrap_mask_s;

    assign incr_s = addr_i + ADDR_WIDTH'(STRB_WIDTH);
    // Byte mask covering the aligned wrap block of (LEN+1) full-width beats.
    assign wrap_mask_s = ((ADDR_WIDTH'(len_i) + ADDR_WIDTH'(1'b1)) << STRB_SHIFT) - ADDR_WIDTH'(1'b1);

    // Pick the next address by burst type; illegal wrap lengths and reserved type fall back to INCR
    always_comb begin
        next_addr_o = incr_s;
        case (burst_i)
            BURST_FIXED: begin
                next_addr_o = addr_i;
            end
            BURST_WRAP: begin
                if (wrap_len_ok(len_i)) begin
                    next_addr_o = (addr_i & ~wrap_mask_s) | (incr_s & wrap_mask_s);
                end else begin
                    next_addr_o = incr_s;
                end
            end
            default: begin
                next_addr_o = incr_s;
            end
        endcase
    end

endmodule

// File: rtl/axi_ram_slave.sv
// AXI4 burst RAM slave: independent write and read engines over one word array.
module axi_ram_slave #(
    parameter  int DATA_WIDTH = 32,
    parameter  int ADDR_WIDTH = 32,
    parameter  int ID_WIDTH   = 1,
    parameter  int MEM_DEPTH  = 1024,
    localparam int STRB_WIDTH = DATA_WIDTH / 8
) (
    input  logic                  ACLK,
    input  logic                  ARESET,
    // write address
    input  logic [ID_WIDTH-1:0]   AWID,
    input  logic [ADDR_WIDTH-1:0] AWADDR,
    input  logic [7:0]            AWLEN,
    input  logic [2:0]            AWSIZE,
    input  logic [1:0]            AWBURST,
    input  logic                  AWVALID,
    output logic                  AWREADY,
    // write data
    input  logic [DATA_WIDTH-1:0] WDATA,
    input  logic [STRB_WIDTH-1:0] WSTRB,
    input  logic                  WLAST,
    input  logic                  WVALID,
    output logic                  WREADY,
    // write response
    output logic [ID_WIDTH-1:0]   BID,
    output logic [1:0]            BRESP,
    output logic                  BVALID,
    input  logic                  BREADY,
    // read address
    input  logic [ID_WIDTH-1:0]   ARID,
    input  logic [ADDR_WIDTH-1:0] ARADDR,
    input  logic [7:0]            ARLEN,
    input  logic [2:0]            ARSIZE,
    input  logic [1:0]            ARBURST,
    input  logic                  ARVALID,
    output logic                  ARREADY,
    // read data
    output logic [ID_WIDTH-1:0]   RID,
    output logic [DATA_WIDTH-1:0] RDATA,
    output logic [1:0]            RRESP,
    output logic                  RLAST,
    output logic                  RVALID,
    input  logic                  RREADY
);
    import axi_ram_slave_pkg::*;

    localparam int STRB_SHIFT  = $clog2(STRB_WIDTH);
    localparam int IDX_WIDTH   = $clog2(MEM_DEPTH);
    localparam int RANGE_SHIFT = IDX_WIDTH + STRB_SHIFT;

    // Any set bit above the array's byte span means the beat falls outside memory.
    function automatic logic addr_oor(input logic [ADDR_WIDTH-1:0] a);
        return |(a >> RANGE_SHIFT);
    endfunction

    function automatic logic [IDX_WIDTH-1:0] word_idx(input logic [ADDR_WIDTH-1:0] a);
        return a[RANGE_SHIFT-1:STRB_SHIFT];
    endfunction

    logic [DATA_WIDTH-1:0] mem_q [MEM_DEPTH];

    // Size is accepted for protocol completeness; every beat is full width.
    logic unused_size_s;
    assign unused_size_s = ^{AWSIZE, ARSIZE};

    // ---------------- write side ----------------
    w_state_e              w_state_q;
    logic                  awready_q, wready_q, bvalid_q;
    logic [ID_WIDTH-1:0]   bid_q;
    logic [1:0]            bresp_q;
    logic [ADDR_WIDTH-1:0] waddr_q, w_next_addr_d;
    logic [7:0]            wlen_q, wcnt_q;
    logic [1:0]            wburst_q;
    logic                  werr_q;
    logic                  aw_fire_s, w_fire_s, b_fire_s;
    logic                  w_last_beat_s, w_oor_s, w_beat_err_s;

    assign aw_fire_s     = AWVALID && awready_q;
    assign w_fire_s      = WVALID && wready_q && !ARESET;
    assign b_fire_s      = bvalid_q && BREADY;
    assign w_last_beat_s = (wcnt_q == wlen_q);
    assign w_oor_s       = addr_oor(waddr_q);
    assign w_beat_err_s  = w_oor_s || (WLAST != w_last_beat_s);

    axi_burst_addr #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .STRB_WIDTH (STRB_WIDTH)
    ) u_waddr (
        .addr_i      (waddr_q),
        .len_i       (wlen_q),
        .burst_i     (wburst_q),
        .next_addr_o (w_next_addr_d)
    );

    // Write FSM: accept AW, consume LEN+1 beats, then hold the response until taken
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            w_state_q <= W_IDLE;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b0;
            bid_q     <= {ID_WIDTH{1'b0}};
            bresp_q   <= RESP_OKAY;
            waddr_q   <= {ADDR_WIDTH{1'b0}};
            wlen_q    <= 8'd0;
            wburst_q  <= BURST_FIXED;
            wcnt_q    <= 8'd0;
            werr_q    <= 1'b0;
        end else begin
            case (w_state_q)
                W_IDLE: begin
                    awready_q <= 1'b1;
                    if (aw_fire_s) begin
                        bid_q     <= AWID;
                        waddr_q   <= AWADDR;
                        wlen_q    <= AWLEN;
                        wburst_q  <= AWBURST;
                        wcnt_q    <= 8'd0;
                        werr_q    <= 1'b0;
                        awready_q <= 1'b0;
                        wready_q  <= 1'b1;
                        w_state_q <= W_DATA;
                    end
                end
                W_DATA: begin
                    if (w_fire_s) begin
                        waddr_q <= w_next_addr_d;
                        wcnt_q  <= wcnt_q + 8'd1;
                        werr_q  <= werr_q || w_beat_err_s;
                        // The beat count, not WLAST, decides where the burst ends.
                        if (w_last_beat_s) begin
                            wready_q  <= 1'b0;
                            bvalid_q  <= 1'b1;
                            bresp_q   <= (werr_q || w_beat_err_s) ? RESP_SLVERR : RESP_OKAY;
                            w_state_q <= W_RESP;
                        end
                    end
                end
                W_RESP: begin
                    if (b_fire_s) begin
                        bvalid_q  <= 1'b0;
                        bresp_q   <= RESP_OKAY;
                        awready_q <= 1'b1;
                        w_state_q <= W_IDLE;
                    end
                end
                default: begin
                    awready_q <= 1'b0;
                    wready_q  <= 1'b0;
                    bvalid_q  <= 1'b0;
                    w_state_q <= W_IDLE;
                end
            endcase
        end
    end

    // Byte-lane write into the array; out-of-range beats are absorbed without effect
    always_ff @(posedge ACLK) begin
        if (w_fire_s && !w_oor_s) begin
            for (int i = 0; i < STRB_WIDTH; i++) begin
                if (WSTRB[i]) begin
                    mem_q[word_idx(waddr_q)][8*i +: 8] <= WDATA[8*i +: 8];
                end
            end
        end
    end

    // ---------------- read side ----------------
    r_state_e              r_state_q;
    logic                  arready_q, rvalid_q, rlast_q;
    logic [ID_WIDTH-1:0]   rid_q;
    logic [DATA_WIDTH-1:0] rdata_q;
    logic [1:0]            rresp_q;
    logic [ADDR_WIDTH-1:0] raddr_q, r_next_addr_d;
    logic [7:0]            rlen_q, rcnt_q;
    logic [1:0]            rburst_q;
    logic                  ar_fire_s, r_fire_s;
    logic [ADDR_WIDTH-1:0] rd_addr_s;
    logic                  rd_oor_s;
    logic [DATA_WIDTH-1:0] rd_word_s;

    assign ar_fire_s = ARVALID && arready_q;
    assign r_fire_s  = rvalid_q && RREADY;

    axi_burst_addr #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .STRB_WIDTH (STRB_WIDTH)
    ) u_raddr (
        .addr_i      (raddr_q),
        .len_i       (rlen_q),
        .burst_i     (rburst_q),
        .next_addr_o (r_next_addr_d)
    );

    // Fetch the word for the beat that will be presented after this edge
    always_comb begin
        rd_addr_s = r_next_addr_d;
        if (ar_fire_s) begin
            rd_addr_s = ARADDR;
        end else begin
            rd_addr_s = r_next_addr_d;
        end
        rd_oor_s  = addr_oor(rd_addr_s);
        rd_word_s = {DATA_WIDTH{1'b0}};
        if (rd_oor_s) begin
            rd_word_s = {DATA_WIDTH{1'b0}};
        end else begin
            rd_word_s = mem_q[word_idx(rd_addr_s)];
        end
    end

    // Read FSM: registered beat outputs only change on AR accept or R handshake
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            r_state_q <= R_IDLE;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rlast_q   <= 1'b0;
            rid_q     <= {ID_WIDTH{1'b0}};
            rdata_q   <= {DATA_WIDTH{1'b0}};
            rresp_q   <= RESP_OKAY;
            raddr_q   <= {ADDR_WIDTH{1'b0}};
            rlen_q    <= 8'd0;
            rburst_q  <= BURST_FIXED;
            rcnt_q    <= 8'd0;
        end else begin
            case (r_state_q)
                R_IDLE: begin
                    arready_q <= 1'b1;
                    if (ar_fire_s) begin
                        rid_q     <= ARID;
                        raddr_q   <= ARADDR;
                        rlen_q    <= ARLEN;
                        rburst_q  <= ARBURST;
                        rcnt_q    <= 8'd0;
                        rdata_q   <= rd_word_s;
                        rresp_q   <= rd_oor_s ? RESP_SLVERR : RESP_OKAY;
                        rlast_q   <= (ARLEN == 8'd0);
                        rvalid_q  <= 1'b1;
                        arready_q <= 1'b0;
                        r_state_q <= R_DATA;
                    end
                end
                R_DATA: begin
                    if (r_fire_s) begin
                        if (rlast_q) begin
                            rvalid_q  <= 1'b0;
                            rlast_q   <= 1'b0;
                            rresp_q   <= RESP_OKAY;
                            rdata_q   <= {DATA_WIDTH{1'b0}};
                            arready_q <= 1'b1;
                            r_state_q <= R_IDLE;
                        end else begin
                            raddr_q <= r_next_addr_d;
                            rcnt_q  <= rcnt_q + 8'd1;
                            rdata_q <= rd_word_s;
                            rresp_q <= rd_oor_s ? RESP_SLVERR : RESP_OKAY;
                            rlast_q <= ((rcnt_q + 8'd1) == rlen_q);
                        end
                    end
                end
                default: begin
                    arready_q <= 1'b0;
                    rvalid_q  <= 1'b0;
                    rlast_q   <= 1'b0;
                    r_state_q <= R_IDLE;
                end
            endcase
        end
    end

    assign AWREADY = awready_q;
    assign WREADY  = wready_q;
    assign BVALID  = bvalid_q;
    assign BID     = bid_q;
    assign BRESP   = bresp_q;
    assign ARREADY = arready_q;
    assign RVALID  = rvalid_q;
    assign RID     = rid_q;
    assign RDATA   = rdata_q;
    assign RRESP   = rresp_q;
    assign RLAST   = rlast_q;

endmodule

// File: tb/tb_axi_ram_slave.sv
// Directed scoreboard bench for axi_ram_slave (defaults: 32-bit data, 1024 words).
module tb_axi_ram_slave;

    localparam logic [1:0] FIXED = 2'b00;
    localparam logic [1:0] INCR  = 2'b01;
    localparam logic [1:0] WRAP  = 2'b10;

    logic        ACLK, ARESET;
    logic [0:0]  AWID, ARID, BID, RID;
    logic [31:0] AWADDR, ARADDR, WDATA, RDATA;
    logic [7:0]  AWLEN, ARLEN;
    logic [2:0]  AWSIZE, ARSIZE;
    logic [1:0]  AWBURST, ARBURST, BRESP, RRESP;
    logic        AWVALID, AWREADY, WLAST, WVALID, WREADY, BVALID, BREADY;
    logic        ARVALID, ARREADY, RLAST, RVALID, RREADY;
    logic [3:0]  WSTRB;

    axi_ram_slave dut (
        .ACLK(ACLK), .ARESET(ARESET),
        .AWID(AWID), .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE), .AWBURST(AWBURST),
        .AWVALID(AWVALID), .AWREADY(AWREADY),
        .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
        .BID(BID), .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
        .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE), .ARBURST(ARBURST),
        .ARVALID(ARVALID), .ARREADY(ARREADY),
        .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY)
    );

    initial ACLK = 1'b0;
    always #5 ACLK = ~ACLK;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic [31:0] data;
        logic [1:0]  resp;
        logic        last;
        logic        id;
    } rbeat_t;

    rbeat_t     rq[$];
    logic [2:0] bq[$];            // {id, resp}
    logic [31:0] mem_m [1024];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Reference address sequencing written with block arithmetic.
    function automatic logic [31:0] nxt(input logic [31:0] a, input logic [7:0] len, input logic [1:0] b);
        logic [31:0] blk;
        if (b == FIXED) return a;
        if (b == WRAP && (len == 8'd1 || len == 8'd3 || len == 8'd7 || len == 8'd15)) begin
            blk = (32'(len) + 32'd1) * 32'd4;
            return (a / blk) * blk + ((a % blk) + 32'd4) % blk;
        end
        return a + 32'd4;
    endfunction

    task automatic do_write(input logic [31:0] addr, input logic [7:0] len, input logic [1:0] burst,
                            input logic [3:0] strb, input logic [31:0] d0, input logic id,
                            input int b_stall, input int abort_after, input bit bad_last);
        logic [31:0] a, wd;
        logic [2:0]  e;
        bit err, ok;
        int wc;
        a = addr; err = bad_last;
        for (int i = 0; i <= int'(len); i++) begin
            if (a >= 32'h1000) err = 1'b1;
            a = nxt(a, len, burst);
        end
        if (abort_after < 0) bq.push_back({id, err ? 2'b10 : 2'b00});
        AWID = id; AWADDR = addr; AWLEN = len; AWBURST = burst; AWSIZE = 3'd2; AWVALID = 1'b1;
        ok = 1'b0;
        for (int k = 0; k < 20 && !ok; k++) begin
            ok = AWREADY; @(posedge ACLK); #1;
        end
        AWVALID = 1'b0;
        check("aw_accept", 64'(ok), 64'd1);
        check("wready_latency", 64'(WREADY), 64'd1);
        a = addr; wc = 0;
        for (int i = 0; i <= int'(len); i++) begin
            if (abort_after >= 0 && i == abort_after) return;
            wd = d0 + 32'(i);
            WDATA = wd; WSTRB = strb; WVALID = 1'b1;
            WLAST = bad_last ? (i != int'(len)) : (i == int'(len));
            ok = 1'b0;
            for (int k = 0; k < 20 && !ok; k++) begin
                ok = WREADY; @(posedge ACLK); #1; wc++;
            end
            if (ok && a < 32'h1000) begin
                for (int b = 0; b < 4; b++)
                    if (strb[b]) mem_m[a[11:2]][8*b +: 8] = wd[8*b +: 8];
            end
            a = nxt(a, len, burst);
        end
        WVALID = 1'b0; WLAST = 1'b0;
        check("w_cycles", 64'(wc), 64'(int'(len) + 1));
        check("bvalid_latency", 64'(BVALID), 64'd1);
        e = bq.pop_front();
        BREADY = 1'b0;
        repeat (b_stall) begin
            @(posedge ACLK); #1;
            check("bvalid_hold", 64'(BVALID), 64'd1);
            check("bid_hold", 64'(BID), 64'(e[2]));
        end
        check("bresp", 64'(BRESP), 64'(e[1:0]));
        check("bid", 64'(BID), 64'(e[2]));
        BREADY = 1'b1; @(posedge ACLK); #1; BREADY = 1'b0;
        check("bvalid_clear", 64'(BVALID), 64'd0);
    endtask

    task automatic do_read(input logic [31:0] addr, input logic [7:0] len, input logic [1:0] burst,
                           input logic id, input int stall_beat, input int stall);
        logic [31:0] a, held;
        rbeat_t e;
        bit ok;
        int beat, c;
        a = addr;
        for (int i = 0; i <= int'(len); i++) begin
            e.data = (a < 32'h1000) ? mem_m[a[11:2]] : 32'h0;
            e.resp = (a < 32'h1000) ? 2'b00 : 2'b10;
            e.last = (i == int'(len));
            e.id   = id;
            rq.push_back(e);
            a = nxt(a, len, burst);
        end
        ARID = id; ARADDR = addr; ARLEN = len; ARBURST = burst; ARSIZE = 3'd2; ARVALID = 1'b1;
        ok = 1'b0;
        for (int k = 0; k < 20 && !ok; k++) begin
            ok = ARREADY; @(posedge ACLK); #1;
        end
        ARVALID = 1'b0;
        check("ar_accept", 64'(ok), 64'd1);
        check("rvalid_latency", 64'(RVALID), 64'd1);
        RREADY = 1'b1; beat = 0; c = 0;
        while (beat <= int'(len) && c < 64) begin
            if (RVALID) begin
                if (stall > 0 && beat == stall_beat) begin
                    RREADY = 1'b0; held = RDATA;
                    repeat (stall) begin
                        @(posedge ACLK); #1;
                        check("rdata_hold", 64'(RDATA), 64'(held));
                        check("rvalid_hold", 64'(RVALID), 64'd1);
                    end
                    RREADY = 1'b1;
                end
                e = rq.pop_front();
                check("rdata", 64'(RDATA), 64'(e.data));
                check("rresp", 64'(RRESP), 64'(e.resp));
                check("rlast", 64'(RLAST), 64'(e.last));
                check("rid", 64'(RID), 64'(e.id));
                beat++;
            end
            @(posedge ACLK); #1; c++;
        end
        RREADY = 1'b0;
        rq.delete();
        check("r_cycles", 64'(c), 64'(int'(len) + 1));
        check("rvalid_clear", 64'(RVALID), 64'd0);
    endtask

    initial begin
        ARESET = 1'b1;
        AWID = 1'b0; AWADDR = 32'h0; AWLEN = 8'd0; AWSIZE = 3'd2; AWBURST = INCR; AWVALID = 1'b0;
        WDATA = 32'h0; WSTRB = 4'h0; WLAST = 1'b0; WVALID = 1'b0; BREADY = 1'b0;
        ARID = 1'b0; ARADDR = 32'h0; ARLEN = 8'd0; ARSIZE = 3'd2; ARBURST = INCR; ARVALID = 1'b0;
        RREADY = 1'b0;

        // reset state
        repeat (3) @(posedge ACLK);
        #1;
        check("rst_awready", 64'(AWREADY), 64'd0);
        check("rst_arready", 64'(ARREADY), 64'd0);
        check("rst_wready", 64'(WREADY), 64'd0);
        check("rst_bvalid", 64'(BVALID), 64'd0);
        check("rst_rvalid", 64'(RVALID), 64'd0);
        check("rst_rlast", 64'(RLAST), 64'd0);
        check("rst_bresp", 64'(BRESP), 64'd0);
        check("rst_rresp", 64'(RRESP), 64'd0);
        ARESET = 1'b0;
        @(posedge ACLK); #1;
        check("post_rst_awready", 64'(AWREADY), 64'd1);
        check("post_rst_arready", 64'(ARREADY), 64'd1);

        // INCR write/read with B and R back-pressure
        do_write(32'h10, 8'd3, INCR, 4'hF, 32'hA0, 1'b1, 5, -1, 1'b0);
        do_read(32'h10, 8'd3, INCR, 1'b0, 1, 3);
        // WRAP read: words 6,7,4,5
        do_read(32'h18, 8'd3, WRAP, 1'b1, -1, 0);

        // byte-strobe merge
        do_write(32'h40, 8'd0, INCR, 4'hF, 32'h11223344, 1'b0, 0, -1, 1'b0);
        do_write(32'h40, 8'd0, INCR, 4'h3, 32'hDEADBEEF, 1'b0, 0, -1, 1'b0);
        do_read(32'h40, 8'd0, INCR, 1'b0, -1, 0);
        check("strobe_merge_model", 64'(mem_m[16]), 64'h1122BEEF);

        // out-of-range write must not alias onto word 0
        do_write(32'h0, 8'd0, INCR, 4'hF, 32'h55AA55AA, 1'b0, 0, -1, 1'b0);
        do_write(32'h1000, 8'd0, INCR, 4'hF, 32'h99999999, 1'b1, 0, -1, 1'b0);
        do_read(32'h0, 8'd0, INCR, 1'b0, -1, 0);
        do_read(32'h1000, 8'd0, INCR, 1'b1, -1, 0);

        // burst crossing the top of memory
        do_write(32'hFF8, 8'd3, INCR, 4'hF, 32'hD0, 1'b0, 0, -1, 1'b0);
        do_read(32'hFF8, 8'd3, INCR, 1'b0, -1, 0);

        // FIXED burst keeps hitting one word
        do_write(32'h80, 8'd2, FIXED, 4'hF, 32'hC0, 1'b1, 0, -1, 1'b0);
        do_read(32'h80, 8'd1, FIXED, 1'b1, -1, 0);

        // WRAP write of two beats, and WRAP with illegal length acting as INCR
        do_write(32'h2C, 8'd1, WRAP, 4'hF, 32'hE0, 1'b0, 0, -1, 1'b0);
        do_read(32'h28, 8'd1, INCR, 1'b0, -1, 0);
        do_write(32'h64, 8'd2, WRAP, 4'hF, 32'hF0, 1'b0, 0, -1, 1'b0);
        do_read(32'h64, 8'd2, INCR, 1'b0, -1, 0);

        // WLAST disagreeing with the beat count
        do_write(32'h100, 8'd1, INCR, 4'hF, 32'h70, 1'b1, 0, -1, 1'b1);
        do_read(32'h100, 8'd1, INCR, 1'b1, -1, 0);

        // reset after two of four write beats
        do_write(32'h200, 8'd3, INCR, 4'hF, 32'hB0, 1'b0, 0, 2, 1'b0);
        WVALID = 1'b0; WLAST = 1'b0;
        ARESET = 1'b1;
        @(posedge ACLK); #1;
        check("midrst_wready", 64'(WREADY), 64'd0);
        check("midrst_bvalid", 64'(BVALID), 64'd0);
        check("midrst_awready", 64'(AWREADY), 64'd0);
        ARESET = 1'b0;
        @(posedge ACLK); #1;
        check("midrst_awready_release", 64'(AWREADY), 64'd1);
        do_read(32'h200, 8'd1, INCR, 1'b0, -1, 0);
        do_write(32'h208, 8'd1, INCR, 4'hF, 32'h31, 1'b1, 0, -1, 1'b0);
        do_read(32'h200, 8'd3, INCR, 1'b1, -1, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
